// File: rtl/rs232_rx_fifo_pkg.sv
// Shared definitions for the RS-232 receive buffer: capture FSM encoding,
// default depth and status-word bit layout used by the CPU I/O mux.
package rs232_rx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        DRAIN = 2'd2
    } cap_state_t;

    localparam int DEFAULT_DEPTH_LOG2 = 4;

    localparam int STAT_RX_RDY    = 0;
    localparam int STAT_TX_RDY    = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;

endpackage

// File: rtl/rs232_rx_fifo_fifo.sv
// Generic first-word-fall-through FIFO: circular storage, wrapping pointers
// and a separate occupancy count. Push is refused when full, pop when empty.
module sync_fifo_fwft #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Full/empty come from the count before this cycle's pop, so a pop never frees room for a same-cycle push.
    assign empty     = (count_r == CNT_ZERO);
    assign full      = (count_r == FULL_COUNT);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign count     = count_r;
    assign rd_data   = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array write port; contents need no reset since reads are gated by count.
    always_ff @(posedge clk) begin
        if (!reset && do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rs232_rx_fifo.sv
// Receive buffer between the RS-232 receiver and the CPU I/O registers:
// captures each byte with a one-cycle done handshake and tracks overflow.
module rs232_rx_fifo
    import rs232_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_rdy,
    input  logic [WIDTH-1:0]      rx_data,
    output logic                  rx_done,
    input  logic                  rd_pop,
    input  logic                  clr_ovf,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rdy,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf
);

    cap_state_t       state_r;
    cap_state_t       state_nxt_s;
    logic             rx_rdy_r;
    logic [WIDTH-1:0] rx_data_r;
    logic             push_s;
    logic             drop_s;
    logic             empty_s;
    logic             full_s;
    logic             ovf_r;

    // Receiver handshake inputs are registered once, so a byte seen at edge N is stored at edge N+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_rdy_r  <= 1'b0;
            rx_data_r <= {WIDTH{1'b0}};
        end else begin
            rx_rdy_r  <= rx_rdy;
            rx_data_r <= rx_data;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_nxt_s;
    end

    // Capture FSM next state and push/drop decisions.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_rdy_r) begin
                    state_nxt_s = ACK;
                    push_s      = ~full_s;
                    drop_s      = full_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK:   state_nxt_s = DRAIN;
            DRAIN: begin
                if (rx_rdy_r) state_nxt_s = DRAIN;
                else          state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset)        ovf_r <= 1'b0;
        else if (drop_s)  ovf_r <= 1'b1;
        else if (clr_ovf) ovf_r <= 1'b0;
        else              ovf_r <= ovf_r;
    end

    sync_fifo_fwft #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (rx_data_r),
        .pop       (rd_pop),
        .rd_data   (rd_data),
        .empty     (empty_s),
        .full      (full_s),
        .count     (count)
    );

    assign rx_done = (state_r == ACK);
    assign rdy     = ~empty_s;
    assign full    = full_s;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed self-checking bench for rs232_rx_fifo.
module tb_rs232_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done;
    logic       rd_pop = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic       rdy;
    logic       full;
    logic [4:0] count;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    rs232_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rd_pop  (rd_pop),
        .clr_ovf (clr_ovf),
        .rd_data (rd_data),
        .rdy     (rdy),
        .full    (full),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: raise rdy, drop it once done is seen, count done pulses in a fixed window.
    task automatic send_byte(input logic [7:0] b, output int dones);
        dones   = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rx_done) begin
                dones++;
                rx_rdy = 1'b0;
            end
        end
        rx_rdy = 1'b0;
    endtask

    task automatic pop_one();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got %0b want 0", rx_done); end
        n_checks++; if (count !== 5'd0)   begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (rdy !== 1'b0)     begin n_fail++; $display("FAIL reset_rdy got %0b want 0", rdy); end
        n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full got %0b want 0", full); end
        n_checks++; if (ovf !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    endtask

    task automatic test_single();
        int d;
        send_byte(8'h41, d);
        n_checks++; if (d !== 1)           begin n_fail++; $display("FAIL single_done_pulses got %0d want 1", d); end
        n_checks++; if (rdy !== 1'b1)      begin n_fail++; $display("FAIL single_rdy got %0b want 1", rdy); end
        n_checks++; if (rd_data !== 8'h41) begin n_fail++; $display("FAIL single_rd_data got %h want 41", rd_data); end
        n_checks++; if (count !== 5'd1)    begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        pop_one();
        n_checks++; if (rdy !== 1'b0)      begin n_fail++; $display("FAIL single_pop_rdy got %0b want 0", rdy); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL single_pop_rd_data got %h want 00", rd_data); end
    endtask

    task automatic test_fill_overflow();
        int d;
        for (int i = 0; i < 16; i++) send_byte(8'(i), d);
        n_checks++; if (full !== 1'b1)   begin n_fail++; $display("FAIL fill_full got %0b want 1", full); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d want 16", count); end
        n_checks++; if (ovf !== 1'b0)    begin n_fail++; $display("FAIL fill_ovf got %0b want 0", ovf); end
        send_byte(8'hAA, d);
        n_checks++; if (d !== 1)         begin n_fail++; $display("FAIL ovf_done_pulses got %0d want 1", d); end
        n_checks++; if (ovf !== 1'b1)    begin n_fail++; $display("FAIL ovf_set got %0b want 1", ovf); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", count); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL fill_order[%0d] got %h want %h", i, rd_data, 8'(i)); end
            pop_one();
        end
        n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL fill_drain_count got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        int d;
        for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i), d);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (rd_data !== 8'h80 + 8'(i)) begin n_fail++; $display("FAIL wrap_a[%0d] got %h want %h", i, rd_data, 8'h80 + 8'(i)); end
            pop_one();
        end
        for (int i = 0; i < 12; i++) send_byte(8'hC0 + 8'(i), d);
        n_checks++; if (count !== 5'd12) begin n_fail++; $display("FAIL wrap_count12 got %0d want 12", count); end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (rd_data !== 8'hC0 + 8'(i)) begin n_fail++; $display("FAIL wrap_b[%0d] got %h want %h", i, rd_data, 8'hC0 + 8'(i)); end
            pop_one();
        end
        n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL wrap_end_count got %0d want 0", count); end
    endtask

    task automatic test_push_pop_same();
        int d;
        send_byte(8'h33, d);
        rx_data = 8'h55;
        rx_rdy  = 1'b1;
        tick();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        rx_rdy = 1'b0;
        n_checks++; if (rx_done !== 1'b1)  begin n_fail++; $display("FAIL pp_rx_done got %0b want 1", rx_done); end
        n_checks++; if (count !== 5'd1)    begin n_fail++; $display("FAIL pp_count got %0d want 1", count); end
        n_checks++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL pp_rd_data got %h want 55", rd_data); end
        for (int i = 0; i < 3; i++) tick();
        pop_one();
        n_checks++; if (count !== 5'd0)    begin n_fail++; $display("FAIL pp_end_count got %0d want 0", count); end
    endtask

    task automatic test_held_rdy();
        int d;
        d = 0;
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_done) d++;
        end
        n_checks++; if (d !== 1)         begin n_fail++; $display("FAIL held_done_pulses got %0d want 1", d); end
        n_checks++; if (count !== 5'd1)  begin n_fail++; $display("FAIL held_count got %0d want 1", count); end
        rx_rdy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (count !== 5'd1)  begin n_fail++; $display("FAIL held_release_count got %0d want 1", count); end
        send_byte(8'h78, d);
        n_checks++; if (count !== 5'd2)  begin n_fail++; $display("FAIL held_next_count got %0d want 2", count); end
        n_checks++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL held_head got %h want 77", rd_data); end
        pop_one();
        n_checks++; if (rd_data !== 8'h78) begin n_fail++; $display("FAIL held_second got %h want 78", rd_data); end
        pop_one();
    endtask

    task automatic test_ovf_reset();
        int d;
        n_checks++; if (ovf !== 1'b1)     begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", ovf); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_checks++; if (ovf !== 1'b0)     begin n_fail++; $display("FAIL ovf_clear got %0b want 0", ovf); end
        rx_data = 8'h99;
        rx_rdy  = 1'b1;
        tick();
        tick();
        n_checks++; if (rx_done !== 1'b1) begin n_fail++; $display("FAIL rst_in_ack_done got %0b want 1", rx_done); end
        reset  = 1'b1;
        rx_rdy = 1'b0;
        tick();
        reset  = 1'b0;
        n_checks++; if (count !== 5'd0)   begin n_fail++; $display("FAIL rst_ack_count got %0d want 0", count); end
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL rst_ack_done got %0b want 0", rx_done); end
        n_checks++; if (rdy !== 1'b0)     begin n_fail++; $display("FAIL rst_ack_rdy got %0b want 0", rdy); end
        pop_one();
        n_checks++; if (count !== 5'd0)   begin n_fail++; $display("FAIL underflow_count got %0d want 0", count); end
        send_byte(8'h5A, d);
        n_checks++; if (d !== 1)          begin n_fail++; $display("FAIL post_rst_done got %0d want 1", d); end
        n_checks++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL post_rst_data got %h want 5a", rd_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_wrap();
        test_push_pop_same();
        test_held_rdy();
        test_ovf_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs232_rx_fifo.md
Name: rs232_rx_fifo

Overview:
Receive-side buffer between the RS-232 receiver (8-bit data, rdy/done handshake) and the CPU I/O data/status registers (I/O words 2 and 3).
- Drains each received byte from the receiver as soon as it appears, so back-to-back characters at the fast bitrate survive CPU latency.
- Presents a first-word-fall-through head byte to the I/O mux.
- Reports occupancy and a sticky overflow flag.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- WIDTH, 8, data width of one entry.

Ports:
- clk  in  1  system clock (25 MHz CPU clock).
- reset  in  1  synchronous, active-high reset.
- rx_rdy  in  1  receiver has a byte (RS232R rdy).
- rx_data  in  WIDTH  receiver byte (RS232R data).
- rx_done  out  1  one-cycle acknowledge to receiver (drives RS232R done).
- rd_pop  in  1  CPU read of data word (rd & ioenb & iowadr==2).
- clr_ovf  in  1  CPU write to control word clears overflow.
- rd_data  out  WIDTH  head entry; 0 when empty.
- rdy  out  1  FIFO non-empty.
- full  out  1  count == 2^DEPTH_LOG2.
- count  out  DEPTH_LOG2+1  current occupancy.
- ovf  out  1  sticky: a byte was dropped.

Behaviour:
Reset (synchronous, active-high, dominates all other inputs):
- rx_done=0, count=0, rdy=0, full=0, ovf=0, rd_data=0.
- Pointers are zeroed; capture FSM goes to IDLE.
- Reset mid-capture abandons the capture: no push, no rx_done.

Storage:
- Circular array of 2^DEPTH_LOG2 entries.
- wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap modulo depth.
- count is tracked separately at DEPTH_LOG2+1 bits.

Capture FSM (states IDLE, ACK, DRAIN):
- IDLE: when rx_rdy=1, go to ACK.
  - If not full (count evaluated before any same-cycle pop): write rx_data at wr_ptr and increment wr_ptr.
  - If full: drop the byte and set ovf=1.
- ACK: rx_done=1 for exactly this cycle, then go to DRAIN.
- DRAIN: rx_done=0; stay until rx_rdy=0, then go to IDLE.
  - This prevents double-capture while the receiver clears rdy.

Latency:
- rx_rdy sampled high at edge N → entry visible (rdy=1, rd_data valid) after edge N+1.
- rx_done is high in the cycle after edge N+1.
- Minimum 3 cycles per byte, far below one character time.

Pop:
- rd_pop with rdy=1 → rd_ptr+1 at the next edge.
- rd_pop with rdy=0 is ignored; no underflow, count stays 0.
- rd_pop is level-sampled each cycle; the CPU asserts it for a single cycle per access.

Simultaneous events:
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full + pop + capture in the same cycle: the push is still rejected (full was evaluated before the pop) and ovf is set. The CPU is expected to read status first.
- Drop + clr_ovf in the same cycle: set wins, ovf stays 1.

Outputs:
- rd_data = mem[rd_ptr] when count≠0, else 0 (combinational from registered array/pointer).
- rdy = (count≠0), full = (count==depth); both derived combinationally from registered count.

Intended top-level use:
- Status word: {count, ovf, full, rdy_tx, rdy}.
- Data word: {24'b0, rd_data}.

Decomposition:
- Shared package holds:
  - capture-state encoding (IDLE=2'd0, ACK=2'd1, DRAIN=2'd2);
  - default depth constant;
  - status-word bit positions (RX_RDY=0, TX_RDY=1, FULL=2, OVF=3, COUNT_LSB=4).
- One natural sub-module, sync_fifo_fwft: generic storage, pointers and count with push/pop/full/empty.
- rs232_rx_fifo wraps it with the capture FSM and the overflow logic.

Test Plan:
1. Reset, then rx_rdy pulse with rx_data=8'h41, receiver model drops rdy on done → rdy=1, rd_data=8'h41, count=1, exactly one rx_done pulse; after rd_pop, rdy=0 and rd_data=0.
2. 16 bytes 8'h00..8'h0F with no pops → full=1, count=16, ovf=0; 17th byte 8'hAA → rx_done still pulses, ovf=1, count=16; 16 pops return 8'h00..8'h0F in order.
3. Wrap-around: push 10, pop 10, push 12, pop 12 → data returned in order across the pointer wrap, count ends at 0.
4. Push 8'h55 in the same cycle as a pop of an existing 8'h33 (count=1) → count stays 1, next rd_data=8'h55.
5. rx_rdy held high for 20 cycles → exactly one push and one rx_done; FSM stays in DRAIN until rx_rdy falls.
6. Set ovf, then clr_ovf → ovf=0. Then reset asserted while the FSM is in ACK → next cycle count=0, rx_done=0, FSM in IDLE; rd_pop on empty leaves count=0.
